iir_coef_sequencer: RTL
=======================

Name: iir_coef_sequencer

Overview:
Controller for one Q3.15 second-order IIR self-trigger filter stage. It owns the stage's five coefficients (n1, n2, n3, d1, d2) and drives the stage's reset and enable lines. It accepts coefficient writes into a shadow bank. On commit, it runs a flush/load/settle sequence so the filter never runs with a mixed coefficient set or stale state. It sits between the slow-control register bus and the filter instance on each channel.

Parameters:
DEF_N1, 18'h078B4, power-up/reset value of n1 (signed Q3.15)
DEF_N2, 18'h3169E, power-up/reset value of n2
DEF_N3, 18'h070AC, power-up/reset value of n3
DEF_D1, 18'h0E3B4, power-up/reset value of d1
DEF_D2, 18'h38F30, power-up/reset value of d2
FLUSH_CYC, 4, cycles filt_reset is held high per flush (1..255)
SETTLE_CYC, 64, cycles after re-enable before out_valid asserts (1..65535)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_wr  in  1  one-cycle shadow write strobe
cfg_addr  in  3  0=n1 1=n2 2=n3 3=d1 4=d2; 5..7 illegal
cfg_data  in  18  signed coefficient value
cfg_commit  in  1  one-cycle request to apply the shadow bank
filter_on  in  1  level; 0 = filter bypassed (raw passthrough)
cfg_ack  out  1  one-cycle pulse: commit accepted
cfg_err  out  1  sticky; illegal address written; cleared by commit
coef_n1..coef_d2  out  18 each  active coefficients to the filter
filt_reset  out  1  active-high reset to the filter
filt_enable  out  1  enable to the filter
busy  out  1  high in any state except RUN
out_valid  out  1  filter output trustworthy

Behaviour:
- Async reset (reset_n=0):
  - Shadow and active banks = DEF_* values.
  - filt_reset=1, filt_enable=0, busy=1, out_valid=0, cfg_ack=0, cfg_err=0.
  - State = FLUSH with counter cleared.
- All outputs are registered. The filter registers its reset/enable once more internally, so the effect appears 1 cycle later at the filter; the counts below refer to this block's outputs.
- Shadow writes are accepted in every state. The active bank changes only in LOAD. An illegal address discards the data and sets cfg_err.
- FSM:
  - RUN:
    - filt_reset=0; filt_enable=filter_on; out_valid=filter_on.
    - On cfg_commit: pulse cfg_ack next cycle, clear cfg_err, go to FLUSH.
    - On filter_on rising: go to FLUSH (state purge after bypass); no ack is issued.
  - FLUSH:
    - filt_reset=1, filt_enable=0, out_valid=0.
    - Hold exactly FLUSH_CYC cycles, then go to LOAD.
  - LOAD:
    - One cycle. Active bank <= shadow bank, all five coefficients in the same edge.
    - filt_reset=0, filt_enable=0. Then go to SETTLE.
  - SETTLE:
    - filt_enable=filter_on; out_valid=0.
    - Count SETTLE_CYC cycles, counting only while filter_on=1.
    - At terminal count go to RUN, where out_valid rises.
- Commit handling outside RUN:
  - cfg_commit during FLUSH or LOAD: latched as pending, acked at LOAD exit. The sequence is not extended; LOAD copies the shadow bank as it stands in that cycle.
  - cfg_commit during SETTLE: abort the settle, ack next cycle, restart at FLUSH with the counter cleared.
- filter_on falling:
  - In RUN: filt_enable and out_valid drop the next cycle; state stays RUN.
  - In SETTLE: the counter freezes.
- Simultaneous cfg_wr and cfg_commit in the same cycle: the write lands in the shadow bank first, so that commit includes it.
- Shadow writes during LOAD: a write in the LOAD cycle itself is not included and stays in shadow for the next commit.
- Coefficient widths are fixed at 18-bit signed two's complement with no saturation. Values pass through unchanged.

Test Plan:
- Release reset_n with filter_on=1 -> filt_reset high for 4 cycles; coef_n1=18'h078B4 and coef_d2=18'h38F30; out_valid rises exactly 4+1+64 cycles after release.
- Write addr0=18'h01000 and addr4=18'h3F000, then commit in RUN -> cfg_ack 1 cycle later; coef outputs unchanged until LOAD; both update in the same clock; the other three remain at their defaults.
- Write addr6 -> cfg_err=1 and no coefficient changes; a subsequent commit clears cfg_err.
- Commit at cycle 30 of SETTLE -> new 4-cycle flush; out_valid stays low until 69 cycles after the second commit's ack.
- Drop filter_on for 10 cycles at cycle 20 of SETTLE -> out_valid rises 10 cycles later than nominal; drop then raise filter_on in RUN -> full flush/settle, with no cfg_ack.
- Assert reset_n=0 mid-SETTLE with a modified active bank -> outputs return to the reset values asynchronously, coefficients return to DEF_*, and the sequence restarts.

Source files
------------

// File: rtl/iir_coef_sequencer_if.sv
// Bundle between the slow-control bus, the coefficient sequencer and one IIR filter stage.
// The master drives configuration and filter_on; the slave is the sequencer.
interface iir_coef_sequencer_if;
  logic               cfg_wr;
  logic [2:0]         cfg_addr;
  logic signed [17:0] cfg_data;
  logic               cfg_commit;
  logic               filter_on;
  logic               cfg_ack;
  logic               cfg_err;
  logic signed [17:0] coef_n1;
  logic signed [17:0] coef_n2;
  logic signed [17:0] coef_n3;
  logic signed [17:0] coef_d1;
  logic signed [17:0] coef_d2;
  logic               filt_reset;
  logic               filt_enable;
  logic               busy;
  logic               out_valid;

  modport master (
    output cfg_wr, cfg_addr, cfg_data, cfg_commit, filter_on,
    input  cfg_ack, cfg_err, coef_n1, coef_n2, coef_n3, coef_d1, coef_d2,
           filt_reset, filt_enable, busy, out_valid
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, cfg_commit, filter_on,
    output cfg_ack, cfg_err, coef_n1, coef_n2, coef_n3, coef_d1, coef_d2,
           filt_reset, filt_enable, busy, out_valid
  );
endinterface

// File: rtl/iir_coef_sequencer.sv
// Shadow/active coefficient banks for one Q3.15 biquad stage, applied through a
// flush -> load -> settle sequence so the filter never mixes coefficient sets.
module iir_coef_sequencer #(
  parameter logic [17:0] DEF_N1     = 18'h078B4,
  parameter logic [17:0] DEF_N2     = 18'h3169E,
  parameter logic [17:0] DEF_N3     = 18'h070AC,
  parameter logic [17:0] DEF_D1     = 18'h0E3B4,
  parameter logic [17:0] DEF_D2     = 18'h38F30,
  parameter int unsigned FLUSH_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 64
) (
  input logic                 clk,
  input logic                 reset_n,
  iir_coef_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_LOAD, S_SETTLE} state_t;

  localparam logic [15:0] FLUSH_LAST  = 16'(FLUSH_CYC - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [17:0] DEF_BANK [5] = '{DEF_N1, DEF_N2, DEF_N3, DEF_D1, DEF_D2};

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_pending;
  logic        r_fon_d;
  logic        r_cfg_ack;
  logic        r_cfg_err;
  logic        r_filt_reset;
  logic        r_filt_enable;
  logic        r_busy;
  logic        r_out_valid;
  logic [17:0] r_shadow [5];
  logic [17:0] r_active [5];

  logic        w_legal_wr;
  logic        w_illegal_wr;

  assign w_legal_wr   = bus.cfg_wr && (bus.cfg_addr <= 3'd4);
  assign w_illegal_wr = bus.cfg_wr && (bus.cfg_addr >  3'd4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 5; i++) r_shadow[i] <= DEF_BANK[i];
    end else if (w_legal_wr) begin
      r_shadow[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // Outputs are registered from the state being entered, so each state's levels
  // are visible for exactly the cycles that state is current.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_FLUSH;
      r_cnt         <= '0;
      r_pending     <= 1'b0;
      r_fon_d       <= 1'b0;
      r_cfg_ack     <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_filt_reset  <= 1'b1;
      r_filt_enable <= 1'b0;
      r_busy        <= 1'b1;
      r_out_valid   <= 1'b0;
      for (int i = 0; i < 5; i++) r_active[i] <= DEF_BANK[i];
    end else begin
      r_cfg_ack <= 1'b0;
      r_fon_d   <= bus.filter_on;

      if (bus.cfg_commit)  r_cfg_err <= 1'b0;
      else if (w_illegal_wr) r_cfg_err <= 1'b1;

      case (r_state)
        S_RUN: begin
          // A rising filter_on after bypass purges state the same way a commit does, minus the ack.
          if (bus.cfg_commit || (bus.filter_on && !r_fon_d)) begin
            r_cfg_ack     <= bus.cfg_commit;
            r_state       <= S_FLUSH;
            r_cnt         <= '0;
            r_filt_reset  <= 1'b1;
            r_filt_enable <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b1;
          end else begin
            r_filt_enable <= bus.filter_on;
            r_out_valid   <= bus.filter_on;
          end
        end

        S_FLUSH: begin
          if (bus.cfg_commit) r_pending <= 1'b1;
          if (r_cnt == FLUSH_LAST) begin
            r_state      <= S_LOAD;
            r_cnt        <= '0;
            r_filt_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_LOAD: begin
          for (int i = 0; i < 5; i++) r_active[i] <= r_shadow[i];
          r_cfg_ack     <= r_pending | bus.cfg_commit;
          r_pending     <= 1'b0;
          r_state       <= S_SETTLE;
          r_filt_enable <= bus.filter_on;
        end

        S_SETTLE: begin
          if (bus.cfg_commit) begin
            r_cfg_ack     <= 1'b1;
            r_state       <= S_FLUSH;
            r_cnt         <= '0;
            r_filt_reset  <= 1'b1;
            r_filt_enable <= 1'b0;
          end else begin
            r_filt_enable <= bus.filter_on;
            if (bus.filter_on) begin
              if (r_cnt == SETTLE_LAST) begin
                r_state     <= S_RUN;
                r_cnt       <= '0;
                r_out_valid <= 1'b1;
                r_busy      <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 16'd1;
              end
            end
          end
        end

        default: begin
          r_state      <= S_FLUSH;
          r_cnt        <= '0;
          r_filt_reset <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cfg_ack     = r_cfg_ack;
  assign bus.cfg_err     = r_cfg_err;
  assign bus.filt_reset  = r_filt_reset;
  assign bus.filt_enable = r_filt_enable;
  assign bus.busy        = r_busy;
  assign bus.out_valid   = r_out_valid;
  assign bus.coef_n1     = r_active[0];
  assign bus.coef_n2     = r_active[1];
  assign bus.coef_n3     = r_active[2];
  assign bus.coef_d1     = r_active[3];
  assign bus.coef_d2     = r_active[4];

endmodule
